// File: rtl/vga_pkg.sv
// Shared VGA constants and types for the drawing pipeline.
//   HCOUNT_W / VCOUNT_W : timing counter widths
//   RGB_W               : {r,g,b} colour width, 4 bits per channel
//   ADDR_X_W / ADDR_Y_W : image ROM address split, address = {y, x}
//   IMG_W_DEF/IMG_H_DEF : default image size
//   vga_timing_t        : timing bundle carried through pipeline stages
package vga_pkg;

    localparam int HCOUNT_W  = 11;
    localparam int VCOUNT_W  = 11;
    localparam int RGB_W     = 12;
    localparam int POS_W     = 12;
    localparam int ADDR_X_W  = 6;
    localparam int ADDR_Y_W  = 6;
    localparam int ADDR_W    = ADDR_X_W + ADDR_Y_W;
    localparam int IMG_W_DEF = 48;
    localparam int IMG_H_DEF = 64;

    typedef struct packed {
        logic [HCOUNT_W-1:0] hcount;
        logic                hsync;
        logic                hblnk;
        logic [VCOUNT_W-1:0] vcount;
        logic                vsync;
        logic                vblnk;
    } vga_timing_t;

    localparam int TIMING_W = $bits(vga_timing_t);

endpackage

// File: rtl/signal_delay.sv
// Fixed-latency register chain.
//   clk  : clock
//   rst  : asynchronous active-low reset, clears every stage
//   din  : WIDTH-bit input
//   dout : din delayed by CLK_DEL (>= 1) clock cycles
module signal_delay #(
    parameter int WIDTH   = 8,
    parameter int CLK_DEL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] pipe [CLK_DEL];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < CLK_DEL; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= din;
            for (int i = 1; i < CLK_DEL; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign dout = pipe[CLK_DEL-1];

endmodule

// File: rtl/draw_image_rom.sv
// Image ROM overlay stage. Issues ROM addresses from the VGA counters and the
// image position, then merges the returned pixel into the RGB stream.
// Two-stage pipeline: stage 1 registers rom_addr and the window flag, stage 2
// registers rgb_out; all timing outputs are delayed by 2 clk to stay aligned.
//   clk, rst                  : pixel clock, async active-low reset
//   xpos, ypos                : image top-left corner, latched on vblnk rise
//   hcount_in .. vblnk_in     : incoming VGA timing
//   rgb_in                    : background colour
//   rom_addr                  : {rel_y[5:0], rel_x[5:0]}, 0 outside the image
//   rom_rgb                   : ROM pixel for the rom_addr presented last clk
//   hcount_out .. vblnk_out   : timing delayed 2 clk
//   rgb_out                   : merged colour aligned with timing outputs
module draw_image_rom
    import vga_pkg::*;
#(
    parameter int               IMG_W      = IMG_W_DEF,
    parameter int               IMG_H      = IMG_H_DEF,
    parameter bit               TRANSP_EN  = 1'b0,
    parameter logic [RGB_W-1:0] TRANSP_RGB = 12'hF0F
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [POS_W-1:0]    xpos,
    input  logic [POS_W-1:0]    ypos,
    input  logic [HCOUNT_W-1:0] hcount_in,
    input  logic                hsync_in,
    input  logic                hblnk_in,
    input  logic [VCOUNT_W-1:0] vcount_in,
    input  logic                vsync_in,
    input  logic                vblnk_in,
    input  logic [RGB_W-1:0]    rgb_in,
    output logic [ADDR_W-1:0]   rom_addr,
    input  logic [RGB_W-1:0]    rom_rgb,
    output logic [HCOUNT_W-1:0] hcount_out,
    output logic                hsync_out,
    output logic                hblnk_out,
    output logic [VCOUNT_W-1:0] vcount_out,
    output logic                vsync_out,
    output logic                vblnk_out,
    output logic [RGB_W-1:0]    rgb_out
);

    logic [POS_W-1:0] xpos_r;
    logic [POS_W-1:0] ypos_r;
    logic             vblnk_prev;

    // Position only moves on the vblnk rising edge so a frame is never torn.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            xpos_r     <= '0;
            ypos_r     <= '0;
            vblnk_prev <= 1'b0;
        end else begin
            vblnk_prev <= vblnk_in;
            if (vblnk_in && !vblnk_prev) begin
                xpos_r <= xpos;
                ypos_r <= ypos;
            end
        end
    end

    // 13-bit signed differences: bit 12 set means the beam is left of / above
    // the image, which also covers positions with bit 11 set (never reached).
    logic [12:0] rel_x;
    logic [12:0] rel_y;
    logic        in_win;

    assign rel_x = {2'b00, hcount_in} - {1'b0, xpos_r};
    assign rel_y = {2'b00, vcount_in} - {1'b0, ypos_r};

    assign in_win = ~hblnk_in & ~vblnk_in
                  & ~rel_x[12] & (rel_x < 13'(IMG_W))
                  & ~rel_y[12] & (rel_y < 13'(IMG_H));

    logic in_win_s1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rom_addr  <= '0;
            in_win_s1 <= 1'b0;
        end else begin
            rom_addr  <= in_win ? {rel_y[ADDR_Y_W-1:0], rel_x[ADDR_X_W-1:0]} : '0;
            in_win_s1 <= in_win;
        end
    end

    vga_timing_t timing_in;
    vga_timing_t timing_d;
    logic [RGB_W-1:0] rgb_s1;

    assign timing_in = '{hcount: hcount_in, hsync: hsync_in, hblnk: hblnk_in,
                         vcount: vcount_in, vsync: vsync_in, vblnk: vblnk_in};

    signal_delay #(.WIDTH(TIMING_W), .CLK_DEL(2)) u_timing_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (timing_in),
        .dout (timing_d)
    );

    signal_delay #(.WIDTH(RGB_W), .CLK_DEL(1)) u_rgb_delay (
        .clk  (clk),
        .rst  (rst),
        .din  (rgb_in),
        .dout (rgb_s1)
    );

    // in_win_s1 already excludes blanking, so blank pixels keep the background.
    logic [RGB_W-1:0] rgb_next;

    always_comb begin
        rgb_next = rgb_s1;
        if (in_win_s1 && !(TRANSP_EN && (rom_rgb == TRANSP_RGB))) begin
            rgb_next = rom_rgb;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rgb_out <= '0;
        else      rgb_out <= rgb_next;
    end

    assign hcount_out = timing_d.hcount;
    assign hsync_out  = timing_d.hsync;
    assign hblnk_out  = timing_d.hblnk;
    assign vcount_out = timing_d.vcount;
    assign vsync_out  = timing_d.vsync;
    assign vblnk_out  = timing_d.vblnk;

endmodule
